// File: rtl/uart_rx_multi.sv
// uart_rx_multi: oversampled UART receiver, DATA_BITS (5..9) data bits,
// optional even/odd parity selected at run time, 1 or 2 stop bits.
// Each bit is the 3-sample majority around its centre. A false start
// returns the receiver to idle. Results go out through a valid/ack
// holding register with overrun reporting.
//
// Build option: define UART_RX_BREAK_DETECT_EN to report an all-zero
// frame as a one-clock rx_break pulse instead of delivering it as a word.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | line idle, waiting for a tick that sees the line low
// S_START   | confirming the start bit (majority must be 0)
// S_DATA    | shifting in data bits, LSB first
// S_PARITY  | sampling the parity bit (only when parity is latched on)
// S_STOP    | sampling stop bit(s); frame completes at last decision
// S_WAIT_HIGH | last stop bit was low; wait for the line to go high

module uart_rx_multi #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_baud_tick,
    input  logic                 rx_in,
    input  logic [1:0]           cfg_parity,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 rx_break
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] C_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] C_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] C_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] C_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] C_BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          C_STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [1:0]            r_sync;
    logic                  w_line;

    logic [TW-1:0]         r_tick_cnt;
    logic [TW-1:0]         w_idx;
    logic                  r_s0;
    logic                  r_s1;
    logic                  w_maj;
    logic                  w_dec;
    logic                  w_end;

    logic [BW-1:0]         r_bit_cnt;
    logic                  r_stop_idx;
    logic                  w_last_bit;
    logic                  w_last_stop;
    logic [DATA_BITS-1:0]  r_shift;
    logic [1:0]            r_par_mode;
    logic                  w_par_en;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  w_ferr_final;
    logic                  w_brk;

    // FSM output strobes
    logic                  w_start_det;
    logic                  w_in_frame;
    logic                  w_shift;
    logic                  w_bit_adv;
    logic                  w_par_dec;
    logic                  w_stop_dec;
    logic                  w_stop_adv;
    logic                  w_complete;

    // Two-flop synchroniser; preset high so reset looks like an idle line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], rx_in};
    end

    assign w_line = r_sync[1];

    // r_tick_cnt holds the index of the last tick processed in the current
    // bit; the tick that detects the falling edge is index 0 of the start bit.
    assign w_idx       = (r_tick_cnt == C_LAST) ? '0 : r_tick_cnt + TW'(1);
    assign w_maj       = (r_s0 & r_s1) | (r_s0 & w_line) | (r_s1 & w_line);
    assign w_dec       = rx_baud_tick && (w_idx == C_DEC);
    assign w_end       = rx_baud_tick && (w_idx == C_LAST);
    assign w_last_bit  = (r_bit_cnt == C_BIT_LAST);
    assign w_last_stop = (r_stop_idx == C_STOP_LAST);
    assign w_par_en    = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_baud_tick && !w_line) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_dec && w_maj)  w_state_nxt = S_IDLE;
                else if (w_end)      w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_end && w_last_bit) w_state_nxt = w_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // A break always ends low, so it lands in S_WAIT_HIGH too
                if (w_dec && w_last_stop) w_state_nxt = w_maj ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (rx_baud_tick && w_line) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output strobes driving the datapath
    always_comb begin
        w_start_det = 1'b0;
        w_in_frame  = 1'b0;
        w_shift     = 1'b0;
        w_bit_adv   = 1'b0;
        w_par_dec   = 1'b0;
        w_stop_dec  = 1'b0;
        w_stop_adv  = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start_det = rx_baud_tick && !w_line;
            end
            S_START: begin
                w_in_frame = 1'b1;
            end
            S_DATA: begin
                w_in_frame = 1'b1;
                w_shift    = w_dec;
                w_bit_adv  = w_end;
            end
            S_PARITY: begin
                w_in_frame = 1'b1;
                w_par_dec  = w_dec;
            end
            S_STOP: begin
                w_in_frame = 1'b1;
                w_stop_dec = w_dec;
                w_stop_adv = w_end && !w_last_stop;
                w_complete = w_dec && w_last_stop;
            end
            default: begin
                w_in_frame = 1'b0;
            end
        endcase
    end

    // Oversample counter and the two early majority samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
        end else if (w_start_det) begin
            r_tick_cnt <= '0;
        end else if (rx_baud_tick && w_in_frame) begin
            r_tick_cnt <= w_idx;
            if (w_idx == C_S0) r_s0 <= w_line;
            if (w_idx == C_S1) r_s1 <= w_line;
        end
    end

    // Bit and stop-bit position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_stop_idx <= 1'b0;
        end else if (w_start_det) begin
            r_bit_cnt  <= '0;
            r_stop_idx <= 1'b0;
        end else begin
            if (w_bit_adv)  r_bit_cnt  <= r_bit_cnt + BW'(1);
            if (w_stop_adv) r_stop_idx <= 1'b1;
        end
    end

    // Data shift register, LSB arrives first and ends up in bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_shift <= '0;
        else if (w_shift) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
    end

    // Parity mode is latched at the start edge so mid-frame changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_mode <= 2'b00;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else if (w_start_det) begin
            r_par_mode <= cfg_parity;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            // odd mode (10) inverts the expected XOR, hence the mode[1] term
            if (w_par_dec)  r_perr <= w_maj ^ (^r_shift) ^ r_par_mode[1];
            if (w_stop_dec) r_ferr <= r_ferr | ~w_maj;
        end
    end

    assign w_ferr_final = r_ferr | ~w_maj;

`ifdef UART_RX_BREAK_DETECT_EN
    logic r_pbit;
    logic r_stop_hi;
    logic r_break;

    // Remember the parity bit and whether any stop bit was high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pbit    <= 1'b0;
            r_stop_hi <= 1'b0;
        end else if (w_start_det) begin
            r_pbit    <= 1'b0;
            r_stop_hi <= 1'b0;
        end else begin
            if (w_par_dec)  r_pbit    <= w_maj;
            if (w_stop_dec) r_stop_hi <= r_stop_hi | w_maj;
        end
    end

    assign w_brk = (r_shift == '0) && !(w_par_en && r_pbit) && !r_stop_hi && !w_maj;

    // One-clock break pulse the cycle after completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_break <= 1'b0;
        else        r_break <= w_complete && w_brk;
    end

    assign rx_break = r_break;
`else
    assign w_brk    = 1'b0;
    assign rx_break = 1'b0;
`endif

    // Output holding register: load on completion, clear on accepted ack.
    // Completion wins over ack; overrun only if the old word was not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else if (w_complete && !w_brk) begin
            rx_data       <= r_shift;
            rx_valid      <= 1'b1;
            rx_frame_err  <= w_ferr_final;
            rx_parity_err <= w_par_en & r_perr;
            rx_overrun    <= rx_valid & ~rx_ack;
        end else if (rx_valid && rx_ack) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end
    end

endmodule
